// File: rtl/shift_issue_stage_pkg.sv
// Shared constants, request entry layout and enqueue-time sanitiser for shift_issue_stage.
package shift_issue_stage_pkg;

   localparam logic [1:0]  SH_OP_PASS  = 2'b00;
   localparam logic [1:0]  SH_OP_LL    = 2'b01;
   localparam logic [1:0]  SH_OP_RA    = 2'b10;
   localparam logic [1:0]  SH_OP_RL    = 2'b11;
   localparam int          SH_AMT_BITS = 5;
   localparam logic [31:0] SH_AMT_MAX  = 32'd31;
   localparam int          ENTRY_W     = 70;

   // One buffered request; spare bits pad the entry to the FIFO width.
   typedef struct packed {
      logic [30:0]            spare;
      logic [1:0]             ctl;    // {ctl1, ctl0}
      logic [SH_AMT_BITS-1:0] b;
      logic [31:0]            a;
   } sh_entry_t;

   // Fold every request into something the Shifter handles with a 5-bit amount.
   function automatic sh_entry_t sanitise(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      sh_entry_t s;
      s       = '0;
      s.ctl   = op;
      s.a     = a;
      s.b     = b[SH_AMT_BITS-1:0];
      if (op == SH_OP_PASS) begin
         // pass is a left shift by zero
         s.ctl = SH_OP_LL;
         s.b   = '0;
      end else if (b > SH_AMT_MAX) begin
         if (op == SH_OP_RA) begin
            // arithmetic right by 31 already gives a full sign fill
            s.b = SH_AMT_MAX[SH_AMT_BITS-1:0];
         end else begin
            // logical shifts by >= 32 produce zero: shift a zero operand
            s.a = '0;
            s.b = '0;
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/shift_req_fifo.sv
// Generic DEPTH x W synchronous FIFO with push/pop, occupancy count and head view.
module shift_req_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 70,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_din,
   output logic [W-1:0]  o_head,
   output logic [CW-1:0] o_count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   // Pointers wrap naturally because DEPTH is a power of two; caller guarantees no overflow/underflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_din;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (i_pop)
            r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/shift_issue_stage.sv
// Operand-issue and result-capture stage around the combinational Shifter.
module shift_issue_stage
   import shift_issue_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] sh_a,
   output logic [WIDTH-1:0] sh_b,
   output logic             sh_ctl0,
   output logic             sh_ctl1,
   input  logic [WIDTH-1:0] sh_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_neg,
   output logic             busy
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] w_count;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   sh_entry_t     w_din;
   sh_entry_t     w_head;

   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_zero;
   logic             r_res_neg;

   assign w_empty  = (w_count == '0);
   // in_ready depends on occupancy only; a full FIFO stays not-ready even while popping.
   assign in_ready = (w_count != CW'(DEPTH));
   assign w_push   = in_valid && in_ready;
   assign w_pop    = !w_empty && (!r_res_valid || res_ready);
   assign w_din    = sanitise(in_op, in_a, in_b);

   shift_req_fifo #(.DEPTH(DEPTH), .W(ENTRY_W), .CW(CW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_din),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // Shifter sees the head entry, or all-zero controls when nothing is queued.
   assign sh_a    = w_empty ? '0 : w_head.a;
   assign sh_b    = w_empty ? '0 : {{(WIDTH-SH_AMT_BITS){1'b0}}, w_head.b};
   assign sh_ctl0 = !w_empty && w_head.ctl[0];
   assign sh_ctl1 = !w_empty && w_head.ctl[1];

   // Result register: capture the Shifter output on pop, drop valid once drained with nothing behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_zero  <= 1'b0;
         r_res_neg   <= 1'b0;
      end else if (w_pop) begin
         r_res_valid <= 1'b1;
         r_res_data  <= sh_out;
         r_res_zero  <= (sh_out == '0);
         r_res_neg   <= sh_out[WIDTH-1];
      end else if (r_res_valid && res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_zero  = r_res_zero;
   assign res_neg   = r_res_neg;
   assign busy      = !w_empty || r_res_valid;

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Operand-issue and result-capture stage wrapped around the existing combinational Shifter.
- Accepts shift requests over a valid/ready handshake and buffers them in a small FIFO.
- Sanitises out-of-range shift amounts, drives the Shifter's A/B/ctl0/ctl1 inputs from the FIFO head, and registers the Shifter output with zero/negative flags behind a second valid/ready handshake.

Parameters:
- DEPTH, 2, request FIFO entries; power of two, >= 2.
- WIDTH, 32, datapath width; the only supported value is 32, to match the Shifter.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  FIFO can accept a request
- in_op  in  2  {ctl1,ctl0} encoding: 00 pass, 01 left logical, 10 right arithmetic, 11 right logical
- in_a  in  32  operand to shift
- in_b  in  32  shift amount, unsigned, full width
- sh_a  out  32  to Shifter A
- sh_b  out  32  to Shifter B; bits [31:5] always 0
- sh_ctl0  out  1  to Shifter ctl0
- sh_ctl1  out  1  to Shifter ctl1
- sh_out  in  32  from Shifter out (combinational return)
- res_valid  out  1  result register holds data
- res_ready  in  1  consumer accepts result
- res_data  out  32  registered shift result
- res_zero  out  1  res_data == 0
- res_neg  out  1  res_data[31]
- busy  out  1  FIFO non-empty or res_valid

Behaviour:
- Reset (synchronous, active-high; wins over all other events, including a mid-transfer handshake):
  - count, read pointer and write pointer = 0.
  - res_valid, res_data, res_zero and res_neg = 0.
  - Any in-flight request is discarded.
- in_ready = (count != DEPTH). It is a function of count only, with no same-cycle pop pass-through, so a full FIFO deasserts in_ready even while popping.
- Push occurs when in_valid && in_ready. The request is sanitised at enqueue, and the sanitised form is stored:
  - op 00: ctl0=1, ctl1=0, b=0, a=in_a (pass = left shift by 0).
  - op 01 or 11 with in_b > 31: a=0, b=0, ctl as encoded.
  - op 10 with in_b > 31: a=in_a, b=31 (full sign fill).
  - Otherwise: a=in_a, b=in_b[4:0], ctl = in_op.
- Shifter drive:
  - FIFO non-empty: sh_* = head entry.
  - FIFO empty: sh_a=0, sh_b=0, sh_ctl0=0, sh_ctl1=0.
- Pop/capture occurs when count != 0 && (!res_valid || res_ready). On a pop:
  - res_data <= sh_out.
  - res_zero <= (sh_out == 0).
  - res_neg <= sh_out[31].
  - res_valid <= 1.
  - The read pointer advances.
- When res_valid && res_ready && count == 0: res_valid <= 0; res_data and flags hold their old values.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency and throughput:
  - A request accepted in cycle N into an empty FIFO is presented to the Shifter in N+1, and res_valid is high in N+2.
  - Sustained throughput is 1 request/cycle when res_ready is held high.
- Backpressure: while res_valid && !res_ready, the head and the Shifter drive are held stable and no pop occurs; the FIFO fills, then in_ready drops.
- Ordering: results leave strictly in request order; no entry is dropped or duplicated.
- No combinational path from in_* to sh_* or res_*. The only combinational path into state is sh_out -> res_data.

Decomposition:
- Shared constants include file holds:
  - op encodings SH_OP_PASS=2'b00, SH_OP_LL=2'b01, SH_OP_RA=2'b10, SH_OP_RL=2'b11;
  - SH_AMT_BITS=5 and SH_AMT_MAX=31.
- One sub-module: shift_req_fifo.
  - Generic DEPTH x 70-bit synchronous FIFO (a[32], b[5], ctl[2] per entry, rest spare) with push/pop/count/head.
- Sanitiser and result register stay in shift_issue_stage.
- The bench instantiates the real Shifter and connects the sh_* ports to it.

Test Plan:
- Reset then idle: res_valid=0, in_ready=1, busy=0, sh_ctl0=sh_ctl1=0.
- Single request op=01, a=0x00000001, b=31 with res_ready=1: res_valid in cycle 2 after accept, res_data=0x80000000, res_neg=1, res_zero=0.
- Out-of-range amounts:
  - op=10, a=0x80000000, b=40 -> res_data=0xFFFFFFFF.
  - op=11, a=0xFFFFFFFE, b=32 -> res_data=0, res_zero=1.
  - op=00, a=0x01000000, b=7 -> res_data=0x01000000.
- Backpressure:
  - Hold res_ready=0 and push 0x7FFFFFFF RL by 1, 7, 31: in_ready drops after DEPTH entries beyond the result slot.
  - Release: results exit in order as 0x3FFFFFFF, 0x00FFFFFF, 0x00000000 (res_zero=1 on the last).
- Streaming: back-to-back pushes of 8 random requests with res_ready=1 give 1 result/cycle with no gaps, and every result matches the reference shift model.
- Reset asserted mid-stream with 2 entries buffered and res_valid=1: next cycle count=0, res_valid=0, in_ready=1; post-reset requests complete normally.
